// File: rtl/fila_atendimento_guiche.sv
// -----------------------------------------------------------------------------
// fila_atendimento_guiche
//
// Counter-side dispatcher for the priority service queue. It keeps one waiting
// counter for each of three customer classes: T (highest), C (middle) and
// A (common). When the attendant asks for the next customer, the block calls
// exactly one waiting customer by priority. It then holds that call on the
// display for a fixed service time.
//
// Optional feature macro: ANTI_STARVATION_EN
//    When this macro is defined, A is forced after STARVE_LIMIT consecutive
//    T/C calls made while A customers were waiting.
//    When it is undefined, the block uses strict T > C > A priority only.
//
// Parameters
//    CNT_W          width of each waiting counter (capacity 2^CNT_W-1)
//    SERVICE_CYCLES cycles a call is held (>= 2)
//    STARVE_LIMIT   consecutive non-A calls tolerated while A waits
//
// Ports
//    clk                  rising-edge clock
//    rst                  synchronous active-high reset
//    chegada_t/c/a        one-cycle arrival strobes from the ticket kiosk
//    proximo              attendant request, sampled only while idle (LIVRE)
//    Ts, Cs, As           one-hot call outputs to the counter display
//    ocupado              high while a call is being served (ATENDE)
//    cnt_t, cnt_c, cnt_a  current waiting counts
//    descarte             one-cycle pulse when an arrival hits a full counter
// -----------------------------------------------------------------------------
module fila_atendimento_guiche #(
   parameter int CNT_W          = 4,
   parameter int SERVICE_CYCLES = 8,
   parameter int STARVE_LIMIT   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chegada_t,
   input  logic             chegada_c,
   input  logic             chegada_a,
   input  logic             proximo,
   output logic             Ts,
   output logic             Cs,
   output logic             As,
   output logic             ocupado,
   output logic [CNT_W-1:0] cnt_t,
   output logic [CNT_W-1:0] cnt_c,
   output logic [CNT_W-1:0] cnt_a,
   output logic             descarte
);

   localparam int               TMR_W    = $clog2(SERVICE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SERVICE_CYCLES - 1);

   // Reject parameter values that would give a zero-width timer or a
   // zero-width starvation counter.
   if (SERVICE_CYCLES < 2) begin : g_bad_service
      $error("SERVICE_CYCLES must be at least 2");
   end
   if (STARVE_LIMIT < 1) begin : g_bad_starve
      $error("STARVE_LIMIT must be at least 1");
   end

   typedef enum logic {
      LIVRE  = 1'b0,
      ATENDE = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   // Call register, ordered {T, C, A}.
   logic [2:0]       call_q, call_d;
   logic [CNT_W-1:0] cnt_t_q, cnt_t_d;
   logic [CNT_W-1:0] cnt_c_q, cnt_c_d;
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic             descarte_q, descarte_d;

   logic             any_waiting;
   logic             take;
   logic             force_a;
   logic             sel_t, sel_c, sel_a;
   logic             drop_t, drop_c, drop_a;

   // Returns {drop, next_count}.
   // An arrival together with a selection of the same class cancels out,
   // so a full counter in that case is not a drop.
   function automatic logic [CNT_W:0] next_count(
      input logic [CNT_W-1:0] cnt,
      input logic             inc,
      input logic             dec
   );
      logic [CNT_W-1:0] nxt;
      logic             drop;
      nxt  = cnt;
      drop = 1'b0;
      if (inc && !dec) begin
         if (cnt == CNT_MAX) begin
            drop = 1'b1;
         end else begin
            nxt = cnt + CNT_W'(1);
         end
      end else if (dec && !inc) begin
         nxt = cnt - CNT_W'(1);
      end
      return {drop, nxt};
   endfunction

`ifdef ANTI_STARVATION_EN
   localparam int               STV_W     = $clog2(STARVE_LIMIT + 1);
   localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_LIMIT);

   logic [STV_W-1:0] starve_q, starve_d;

   assign force_a = (cnt_a_q != '0) && (starve_q >= STV_LIMIT);

   // Counts consecutive T/C calls made while A customers are waiting.
   // An A call, or any call made with no A waiting, restarts the count.
   always_comb begin
      starve_d = starve_q;
      if (take) begin
         if (sel_a || (cnt_a_q == '0)) begin
            starve_d = '0;
         end else if (starve_q < STV_LIMIT) begin
            starve_d = starve_q + STV_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign force_a = 1'b0;
`endif

   // Selection always uses the registered counts.
   // This is why an arrival at a zero counter cannot be called in the
   // same cycle as that arrival.
   assign any_waiting = (cnt_t_q != '0) || (cnt_c_q != '0) || (cnt_a_q != '0);
   assign take        = (state_q == LIVRE) && proximo && any_waiting;
   assign sel_t       = take && !force_a && (cnt_t_q != '0);
   assign sel_c       = take && !force_a && (cnt_t_q == '0) && (cnt_c_q != '0);
   assign sel_a       = take && (force_a || ((cnt_t_q == '0) && (cnt_c_q == '0)));

   // Service FSM.
   // The timer is loaded with SERVICE_CYCLES-1 on the call edge. The call
   // is released on the edge that sees the timer at 0, which holds the call
   // for exactly SERVICE_CYCLES cycles. Returning to LIVRE guarantees at
   // least one idle cycle before the next call.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      call_d  = call_q;
      case (state_q)
         LIVRE: begin
            if (take) begin
               state_d = ATENDE;
               timer_d = TMR_LOAD;
               call_d  = {sel_t, sel_c, sel_a};
            end
         end
         ATENDE: begin
            if (timer_q == '0) begin
               state_d = LIVRE;
               call_d  = 3'b000;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         default: begin
            state_d = LIVRE;
            timer_d = '0;
            call_d  = 3'b000;
         end
      endcase
   end

   // Waiting counters.
   // Each counter saturates independently. Simultaneous drops in several
   // classes merge into a single descarte pulse.
   always_comb begin
      {drop_t, cnt_t_d} = next_count(cnt_t_q, chegada_t, sel_t);
      {drop_c, cnt_c_d} = next_count(cnt_c_q, chegada_c, sel_c);
      {drop_a, cnt_a_d} = next_count(cnt_a_q, chegada_a, sel_a);
      descarte_d        = drop_t | drop_c | drop_a;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LIVRE;
         timer_q    <= '0;
         call_q     <= 3'b000;
         cnt_t_q    <= '0;
         cnt_c_q    <= '0;
         cnt_a_q    <= '0;
         descarte_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         call_q     <= call_d;
         cnt_t_q    <= cnt_t_d;
         cnt_c_q    <= cnt_c_d;
         cnt_a_q    <= cnt_a_d;
         descarte_q <= descarte_d;
      end
   end

   assign Ts       = call_q[2];
   assign Cs       = call_q[1];
   assign As       = call_q[0];
   assign ocupado  = (state_q == ATENDE);
   assign cnt_t    = cnt_t_q;
   assign cnt_c    = cnt_c_q;
   assign cnt_a    = cnt_a_q;
   assign descarte = descarte_q;

endmodule

// File: tb/tb_fila_atendimento_guiche.sv
// -----------------------------------------------------------------------------
// tb_fila_atendimento_guiche
//
// Self-checking bench for fila_atendimento_guiche with default parameters.
// A behavioural queue model predicts the outputs after every clock edge.
// Directed scenarios are followed by randomized arrival and request traffic.
// -----------------------------------------------------------------------------
module tb_fila_atendimento_guiche;

   localparam int CNT_W = 4;
   localparam int SVC   = 8;
   localparam int LIM   = 3;
   localparam int MAXC  = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic             chegada_t, chegada_c, chegada_a, proximo;
   logic             Ts, Cs, As, ocupado, descarte;
   logic [CNT_W-1:0] cnt_t, cnt_c, cnt_a;

   int total = 0;
   int bad   = 0;

   // Reference model state, as it will be after the next clock edge.
   int m_cnt[3];
   int m_busy, m_rem, m_cls, m_starve, m_drop;

   // Observation log built from the DUT outputs.
   int         callLog[$];
   int         descCount;
   logic [2:0] prevCall;

   always #5 clk = ~clk;

   fila_atendimento_guiche #(
      .CNT_W         (CNT_W),
      .SERVICE_CYCLES(SVC),
      .STARVE_LIMIT  (LIM)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .chegada_t(chegada_t),
      .chegada_c(chegada_c),
      .chegada_a(chegada_a),
      .proximo  (proximo),
      .Ts       (Ts),
      .Cs       (Cs),
      .As       (As),
      .ocupado  (ocupado),
      .cnt_t    (cnt_t),
      .cnt_c    (cnt_c),
      .cnt_a    (cnt_a),
      .descarte (descarte)
   );

   // Counts one comparison and reports it if the observed value differs.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Queue behaviour from the rules: priority T > C > A, optional forced A,
   // saturating counts, and an arrival plus a call of the same class cancel out.
   task automatic modelStep(input logic t, input logic c, input logic a, input logic p, input logic r);
      int inc[3];
      int sel;
      inc[0] = int'(t);
      inc[1] = int'(c);
      inc[2] = int'(a);
      sel    = -1;
      if (r) begin
         m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0;
         m_busy = 0; m_rem = 0; m_cls = -1; m_starve = 0; m_drop = 0;
      end else begin
         m_drop = 0;
         if (m_busy != 0) begin
            if (m_rem == 0) begin
               m_busy = 0;
               m_cls  = -1;
            end else begin
               m_rem--;
            end
         end else if (p && (m_cnt[0] + m_cnt[1] + m_cnt[2]) > 0) begin
            sel = (m_cnt[0] > 0) ? 0 : ((m_cnt[1] > 0) ? 1 : 2);
`ifdef ANTI_STARVATION_EN
            if (m_cnt[2] > 0 && m_starve >= LIM) sel = 2;
            m_starve = (sel == 2 || m_cnt[2] == 0) ? 0 : m_starve + 1;
`endif
            m_busy = 1;
            m_rem  = SVC - 1;
            m_cls  = sel;
         end
         for (int i = 0; i < 3; i++) begin
            if (inc[i] != 0 && sel != i) begin
               if (m_cnt[i] == MAXC) m_drop = 1;
               else m_cnt[i]++;
            end else if (inc[i] == 0 && sel == i) begin
               m_cnt[i]--;
            end
         end
      end
   endtask

   // Runs one cycle. At the falling edge it checks the DUT against the
   // model and logs call onsets. It then drives the new inputs and advances
   // the model to match the next rising edge.
   task automatic applyStimulus(input logic t, input logic c, input logic a, input logic p, input logic r);
      int expCall;
      @(negedge clk);
      expCall = (m_busy != 0) ? (4 >> m_cls) : 0;
      checkOutput("ocupado",  32'(ocupado),        32'(m_busy));
      checkOutput("calls",    32'({Ts, Cs, As}),   32'(expCall));
      checkOutput("cnt_t",    32'(cnt_t),          32'(m_cnt[0]));
      checkOutput("cnt_c",    32'(cnt_c),          32'(m_cnt[1]));
      checkOutput("cnt_a",    32'(cnt_a),          32'(m_cnt[2]));
      checkOutput("descarte", 32'(descarte),       32'(m_drop));
      if (descarte) descCount++;
      if ({Ts, Cs, As} != 3'b000 && prevCall == 3'b000) begin
         callLog.push_back(Ts ? 0 : (Cs ? 1 : 2));
      end
      prevCall  = {Ts, Cs, As};
      chegada_t = t;
      chegada_c = c;
      chegada_a = a;
      proximo   = p;
      rst       = r;
      modelStep(t, c, a, p, r);
   endtask

   task automatic doReset();
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      callLog.delete();
      descCount = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
   endtask

   initial begin
      int expSeq[$];
      rst = 1'b1;
      chegada_t = 1'b0; chegada_c = 1'b0; chegada_a = 1'b0; proximo = 1'b0;
      prevCall = 3'b000;
      descCount = 0;
      modelStep(0, 0, 0, 0, 1);
      @(posedge clk);

      // One customer of each class; priority order T, C, A with idle gaps.
      doReset();
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      for (int i = 0; i < 3 * (SVC + 1) + 2; i++) applyStimulus(0, 0, 0, 1, 0);
      idle(3);
      checkOutput("prio_n_calls", 32'(callLog.size()), 32'd3);
      if (callLog.size() == 3) begin
         checkOutput("prio_first",  32'(callLog[0]), 32'd0);
         checkOutput("prio_second", 32'(callLog[1]), 32'd1);
         checkOutput("prio_third",  32'(callLog[2]), 32'd2);
      end

      // Saturation: sixteen T arrivals into a 4-bit counter.
      doReset();
      for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 0, 0);
      idle(2);
      checkOutput("sat_cnt_t",   32'(cnt_t),     32'd15);
      checkOutput("sat_drop_ct", 32'(descCount), 32'd1);

      // Arrival at zero count on the selection edge: the call comes one edge later.
      doReset();
      applyStimulus(0, 0, 1, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("arr0_no_call", 32'({Ts, Cs, As}), 32'd0);
      checkOutput("arr0_cnt_a",   32'(cnt_a),        32'd1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("arr0_as_call", 32'(As),    32'd1);
      checkOutput("arr0_cnt_a0",  32'(cnt_a), 32'd0);
      idle(SVC + 1);

      // Arrival and selection of the same class: the count is unchanged.
      doReset();
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("same_ts",    32'(Ts),    32'd1);
      checkOutput("same_cnt_t", 32'(cnt_t), 32'd1);
      idle(SVC + 1);

      // Reset asserted during the fourth service cycle.
      doReset();
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0);
      idle(3);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("rst_ocupado", 32'(ocupado),        32'd0);
      checkOutput("rst_calls",   32'({Ts, Cs, As}),   32'd0);
      checkOutput("rst_cnt_t",   32'(cnt_t),          32'd0);

      // Five T customers and one A customer, with proximo held high.
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      for (int i = 0; i < 6 * (SVC + 1) + 3; i++) applyStimulus(0, 0, 0, 1, 0);
      idle(2);
`ifdef ANTI_STARVATION_EN
      expSeq = '{0, 0, 0, 2, 0, 0};
`else
      expSeq = '{0, 0, 0, 0, 0, 2};
`endif
      checkOutput("starve_n_calls", 32'(callLog.size()), 32'd6);
      if (callLog.size() == 6) begin
         for (int i = 0; i < 6; i++) checkOutput("starve_seq", 32'(callLog[i]), 32'(expSeq[i]));
      end

      // Randomized traffic, alternating light and heavy arrival phases.
      doReset();
      for (int ph = 0; ph < 6; ph++) begin
         int hi;
         hi = (ph % 2 == 0) ? 5 : 1;
         for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, hi) == 0,
                          $urandom_range(0, hi) == 0,
                          $urandom_range(0, hi) == 0,
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 299) == 0);
         end
      end
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
